msk_data_unloader: RTL
======================

Name: msk_data_unloader

Overview:
- Parallel-in, serial-out unloader for masked data. It is the counterpart of the serial-fetch masked data holder.
- Captures a full d-share sharing of BITS bits in one handshake, then emits it as NSTAGES = BITS/RFRSH_RATE chunks of RFRSH_RATE bits per share over a valid/ready stream.
- Sits at the core output (ciphertext / result path), feeding narrow downstream buses whose chunks a serial-fetch holder can re-ingest.

Parameters:
- d, 2, number of shares (>=2).
- BITS, 256, sharing width per share.
- RFRSH_RATE, 16, chunk width per share; MUST divide BITS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- sh_data_in  in  d*BITS  input sharing, shbus encoding: bit k of share i at index k*d+i.
- in_valid  in  1  sh_data_in valid.
- in_ready  out  1  block can capture a sharing.
- sh_chunk_out  out  d*RFRSH_RATE  current chunk, shbus encoding over RFRSH_RATE bits.
- out_valid  out  1  sh_chunk_out valid.
- out_ready  in  1  downstream accepts chunk.
- rnd_rfrsh_in  in  (d-1)*RFRSH_RATE  refresh randomness; present only with the optional feature.

Behaviour:
- Clock is clk. Reset is nrst: synchronous, active-low.
- States: IDLE, SEND. Chunk counter cnt has width clog2(NSTAGES) (minimum 1).
- Reset (nrst=0 at an edge):
  - state=IDLE, cnt=0, out_valid=0.
  - Data registers are not reset. sh_chunk_out is don't-care while out_valid=0.
- Output flags: in_ready = (state==IDLE); out_valid = (state==SEND). Both are pure state decodes with no combinational path from inputs.
- IDLE, on in_valid&in_ready:
  - Capture sh_data_in into per-share shift registers of NSTAGES stages.
  - Stage j gets bits [j*RFRSH_RATE +: RFRSH_RATE] of each share.
  - cnt=0; go to SEND.
- Latency: out_valid rises the cycle after capture, with stage 0 (chunk 0, LSBs) on sh_chunk_out.
- SEND, on out_valid&out_ready:
  - All shares shift by one stage (stage j+1 -> stage j); cnt++.
  - If cnt==NSTAGES-1, go to IDLE instead, so in_ready=1 next cycle.
  - There is one idle bubble between consecutive sharings.
- SEND with out_ready=0: sh_chunk_out and out_valid hold stable (no shift, no refresh).
- Chunk order: 0..NSTAGES-1, least-significant first, so re-ingestion by a serial-fetch holder restores the original bit positions.
- in_valid while in SEND: ignored; no capture.
- NSTAGES==1: a single handshake returns to IDLE.
- nrst low mid-SEND: abort; the remaining chunks are dropped; next state is IDLE.
- Shares are never combined. Each share path uses per-share register/mux cells, so no share-crossing logic exists outside the refresh gadget.

Optional Feature:
- Macro: MSK_UNLOADER_RFRSH_EN.
- Defined:
  - rnd_rfrsh_in port exists.
  - An RFRSH_RATE-bit refresh tree is inserted on the path into stage 0.
  - At capture, chunk 0 is refreshed. On each non-final output handshake, stage 1 is refreshed into stage 0.
  - rnd_rfrsh_in must carry fresh randomness on those cycles; it is ignored otherwise.
  - The unmasked value is unchanged.
- Undefined: the port is absent and stage 0 loads directly with no refresh.

Decomposition:
- Shared package/header holds:
  - the state encoding (IDLE=0, SEND=1);
  - the NSTAGES derivation;
  - the counter width function;
  - the shbus index helper.
- One natural sub-module, msk_data_unloader_ctrl: the FSM plus counter, producing in_ready, out_valid, capture_en and shift_en.
- The datapath in the top uses the existing masked register-enable, mux and refresh-tree cells.

Test Plan (d=2, BITS=32, RFRSH_RATE=8):
1. Reset then idle -> in_ready=1 and out_valid=0 on the first cycle after nrst rises.
2. Capture share0=0x44332211, share1=0x00000000, out_ready=1 -> out_valid from the next cycle for 4 cycles. Per-share chunks are 0x11,0x22,0x33,0x44; the share-XOR is checked per chunk; in_ready=1 on the cycle after the 4th handshake.
3. Backpressure: out_ready toggles 1,0,0,1,... -> sh_chunk_out is stable while out_ready=0. No chunk is lost or duplicated; exactly 4 handshakes occur.
4. in_valid held high through SEND with a different sharing -> second sharing is captured only in IDLE, after the bubble. The first sharing's chunks are uncorrupted.
5. nrst pulled low after 2 chunks -> next cycle state=IDLE, out_valid=0; the next sharing starts at chunk 0.
6. With MSK_UNLOADER_RFRSH_EN, random rnd_rfrsh_in -> each chunk's share-XOR equals the unrefreshed value. Individual shares differ from the input shares for nonzero randomness.

Source files
------------

// File: rtl/msk_data_unloader_pkg.sv
//============================================================================
// Module   : msk_data_unloader_pkg
// Purpose  : Shared types and helpers for the masked parallel-in/serial-out unloader.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package msk_data_unloader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int nstages(input int bits, input int rate);
        return bits / rate;
    endfunction

    // Counter needs at least one bit even for a single-stage configuration
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // shbus layout: bit k of share i lives at k*d+i
    function automatic int shbus_idx(input int k, input int i, input int d);
        return k * d + i;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msk_data_unloader_if.sv
//============================================================================
// Module   : msk_data_unloader_if
// Purpose  : Capture handshake plus chunk stream of the masked data unloader.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface msk_data_unloader_if #(
    parameter int D          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16
);
    logic [D*BITS-1:0]       sh_data_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [D*RFRSH_RATE-1:0] sh_chunk_out;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output sh_data_in, in_valid, out_ready,
        input  in_ready, sh_chunk_out, out_valid
    );

    modport slave (
        input  sh_data_in, in_valid, out_ready,
        output in_ready, sh_chunk_out, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/msk_data_unloader_ctrl.sv
//============================================================================
// Module   : msk_data_unloader_ctrl
// Purpose  : IDLE/SEND sequencer and chunk counter for the masked unloader.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module msk_data_unloader_ctrl
    import msk_data_unloader_pkg::*;
#(
    parameter int NSTAGES = 16,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic capture_en,
    output logic shift_en
);

    state_t             r_state;
    state_t             w_state_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_n;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        in_ready   = (r_state == IDLE);
        out_valid  = (r_state == SEND);
        capture_en = 1'b0;
        shift_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    capture_en = 1'b1;
                    w_cnt_n    = '0;
                    w_state_n  = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    shift_en = 1'b1;
                    if (r_cnt == CNT_W'(NSTAGES - 1)) begin
                        w_state_n = IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/msk_data_unloader.sv
//============================================================================
// Module   : msk_data_unloader
// Purpose  : Captures a d-share sharing and streams it out LSB chunk first.
//            Optional refresh of stage 0 when MSK_UNLOADER_RFRSH_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module msk_data_unloader
    import msk_data_unloader_pkg::*;
#(
    parameter int D          = 2,
    parameter int BITS       = 256,
    parameter int RFRSH_RATE = 16
) (
    input  logic                          clk,
    input  logic                          nrst,
`ifdef MSK_UNLOADER_RFRSH_EN
    input  logic [(D-1)*RFRSH_RATE-1:0]   rnd_rfrsh_in,
`endif
    msk_data_unloader_if.slave            bus
);

    localparam int NSTAGES = nstages(BITS, RFRSH_RATE);
    localparam int CNT_W   = cnt_width(NSTAGES);

    logic w_capture_en;
    logic w_shift_en;

    msk_data_unloader_ctrl #(
        .NSTAGES (NSTAGES),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (bus.in_valid),
        .out_ready  (bus.out_ready),
        .in_ready   (bus.in_ready),
        .out_valid  (bus.out_valid),
        .capture_en (w_capture_en),
        .shift_en   (w_shift_en)
    );

`ifdef MSK_UNLOADER_RFRSH_EN
    // Last share absorbs the XOR of all masks so the unmasked value is kept
    logic [RFRSH_RATE-1:0] w_rnd_sum;
    always_comb begin
        w_rnd_sum = '0;
        for (int s = 0; s < D - 1; s++)
            w_rnd_sum = w_rnd_sum ^ rnd_rfrsh_in[s*RFRSH_RATE +: RFRSH_RATE];
    end
`endif

    for (genvar i = 0; i < D; i++) begin : g_share
        logic [BITS-1:0]       w_share;
        logic [RFRSH_RATE-1:0] w_pre0;
        logic [RFRSH_RATE-1:0] w_post0;
        logic [RFRSH_RATE-1:0] r_stage [NSTAGES];

        for (genvar k = 0; k < BITS; k++) begin : g_bit
            assign w_share[k] = bus.sh_data_in[shbus_idx(k, i, D)];
        end

        if (NSTAGES > 1) begin : g_next
            assign w_pre0 = w_capture_en ? w_share[RFRSH_RATE-1:0] : r_stage[1];
        end else begin : g_single
            assign w_pre0 = w_share[RFRSH_RATE-1:0];
        end

`ifdef MSK_UNLOADER_RFRSH_EN
        if (i < D - 1) begin : g_rfrsh_mask
            assign w_post0 = w_pre0 ^ rnd_rfrsh_in[i*RFRSH_RATE +: RFRSH_RATE];
        end else begin : g_rfrsh_sum
            assign w_post0 = w_pre0 ^ w_rnd_sum;
        end
`else
        assign w_post0 = w_pre0;
`endif

        always_ff @(posedge clk) begin
            if (w_capture_en || w_shift_en)
                r_stage[0] <= w_post0;
            if (w_capture_en) begin
                for (int j = 1; j < NSTAGES; j++)
                    r_stage[j] <= w_share[j*RFRSH_RATE +: RFRSH_RATE];
            end else if (w_shift_en) begin
                for (int j = 1; j < NSTAGES - 1; j++)
                    r_stage[j] <= r_stage[j+1];
            end
        end

        for (genvar b = 0; b < RFRSH_RATE; b++) begin : g_out
            assign bus.sh_chunk_out[shbus_idx(b, i, D)] = r_stage[0][b];
        end
    end

endmodule

`default_nettype wire
